alu_cmd_issuer: RTL and testbench

Command-side controller for the 4-bit combinational ALU. It accepts operation requests over a valid/ready handshake and drives registered operands and select to the ALU. It captures the ALU result one cycle later and returns it, with status flags, over a second valid/ready handshake. It keeps an accumulator so results can be chained, and counts completed operations.

---
 rtl/alu_cmd_issuer.sv | 76 +++++++
 tb/tb_alu_cmd_issuer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Command-side controller for the 4-bit ALU: registers operands and select,
// captures the result one cycle later and returns it over a valid/ready handshake.
module alu_cmd_issuer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic       cmd_use_acc,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [3:0] alu_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_zero,
    output logic       rsp_illegal,
    output logic [3:0] acc,
    output logic [7:0] op_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       ill_q;

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ill_q       <= 1'b0;
            alu_a       <= 4'd0;
            alu_b       <= 4'd0;
            alu_sel     <= 3'd0;
            rsp_data    <= 4'd0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
            acc         <= 4'd0;
            op_count    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a   <= cmd_use_acc ? acc : cmd_a;
                        alu_b   <= cmd_b;
                        alu_sel <= cmd_op;
                        ill_q   <= (cmd_op > 3'd4);
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal ops report a forced zero whatever the ALU drives.
                    rsp_data    <= ill_q ? 4'd0 : alu_out;
                    rsp_zero    <= ill_q | (alu_out == 4'd0);
                    rsp_illegal <= ill_q;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        if (!rsp_illegal)
                            acc <= rsp_data;
                        op_count <= op_count + 8'd1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a queue scoreboard and a model ALU.
module tb_alu_cmd_issuer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_a = 4'd0;
    logic [3:0] cmd_b = 4'd0;
    logic       cmd_use_acc = 1'b0;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [3:0] rsp_data;
    logic       rsp_zero, rsp_illegal;
    logic [3:0] acc;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] data;
        logic       zero;
        logic       ill;
    } rsp_t;
    rsp_t sb[$];

    alu_cmd_issuer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
        .acc(acc), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Model of the combinational ALU; illegal selects drive a nonzero pattern.
    always_comb begin
        case (alu_sel)
            3'd0:    alu_out = alu_a + alu_b;
            3'd1:    alu_out = alu_a - alu_b;
            3'd2:    alu_out = alu_a & alu_b;
            3'd3:    alu_out = alu_a | alu_b;
            3'd4:    alu_out = alu_a ^ alu_b;
            default: alu_out = 4'hB;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every completed response handshake is checked against the queue.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_data", int'(rsp_data), int'(e.data));
                chk("rsp_zero", int'(rsp_zero), int'(e.zero));
                chk("rsp_illegal", int'(rsp_illegal), int'(e.ill));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Called just after a rising edge; returns 1 time unit after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic ua, input logic [3:0] ed, input logic ez, input logic ei);
        int n;
        rsp_t e;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 0, 1);
        e.data = ed; e.zero = ez; e.ill = ei;
        sb.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rsp_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_rsp_zero", int'(rsp_zero), 0);
        chk("rst_rsp_illegal", int'(rsp_illegal), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_b", int'(alu_b), 0);
        chk("rst_alu_sel", int'(alu_sel), 0);
        chk("rst_acc", int'(acc), 0);
        chk("rst_op_count", int'(op_count), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        rst = 1'b0;
        @(posedge clk); #1;

        // add 9+8 with latency checks
        issue(3'd0, 4'd9, 4'd8, 1'b0, 4'd1, 1'b0, 1'b0);
        chk("lat_exec_valid", int'(rsp_valid), 0);
        chk("lat_exec_ready", int'(cmd_ready), 0);
        @(posedge clk); #1;
        chk("lat_resp_valid", int'(rsp_valid), 1);
        wait_rsp();
        chk("add_acc", int'(acc), 1);
        chk("add_cnt", int'(op_count), 1);
        chk("add_ready_after", int'(cmd_ready), 1);

        // illegal op leaves acc alone but counts
        issue(3'd6, 4'd7, 4'd2, 1'b0, 4'd0, 1'b1, 1'b1);
        wait_rsp();
        chk("ill_acc", int'(acc), 1);
        chk("ill_cnt", int'(op_count), 2);

        // sub wraps, then xor chained from acc
        issue(3'd1, 4'd3, 4'd5, 1'b0, 4'd14, 1'b0, 1'b0);
        wait_rsp();
        chk("sub_acc", int'(acc), 14);
        issue(3'd4, 4'd5, 4'd14, 1'b1, 4'd0, 1'b1, 1'b0);
        chk("xor_alu_a", int'(alu_a), 14);
        chk("xor_alu_b", int'(alu_b), 14);
        wait_rsp();
        chk("xor_acc", int'(acc), 0);
        chk("xor_cnt", int'(op_count), 4);

        // backpressure: and 12&10 held, competing command ignored
        rsp_ready = 1'b0;
        issue(3'd2, 4'd12, 4'd10, 1'b0, 4'd8, 1'b0, 1'b0);
        cmd_op = 3'd0; cmd_a = 4'd1; cmd_b = 4'd1; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
        begin
            int n;
            n = 0;
            while (!rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) chk("bp_valid_timeout", 0, 1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", int'(rsp_valid), 1);
            chk("bp_data", int'(rsp_data), 8);
            chk("bp_zero", int'(rsp_zero), 0);
            chk("bp_cmd_ready", int'(cmd_ready), 0);
            chk("bp_alu_sel", int'(alu_sel), 2);
            chk("bp_alu_a", int'(alu_a), 12);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        issue(3'd0, 4'd1, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0);
        wait_rsp();
        chk("bp_acc", int'(acc), 2);
        chk("bp_cnt", int'(op_count), 6);

        // reset during EXEC drops the in-flight or 1|2
        issue(3'd3, 4'd1, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_reset_vals();
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_rsp", int'(rsp_valid), 0);
        end
        @(posedge clk); #1;
        issue(3'd0, 4'd1, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0);
        wait_rsp();
        chk("post_rst_acc", int'(acc), 2);
        chk("post_rst_cnt", int'(op_count), 1);

        // 256 add 0+0: counter wraps back to 0
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            issue(3'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
            wait_rsp();
            if (i == 254) chk("wrap_cnt_255", int'(op_count), 255);
        end
        chk("wrap_cnt_0", int'(op_count), 0);
        chk("wrap_acc", int'(acc), 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
